// File: rtl/countdown_timer_mmss_if.sv
// Control/load inputs and BCD display/status outputs of the mm:ss kitchen-timer.
// The master side drives load/run controls; the slave side is the timer itself.
interface countdown_timer_mmss_if;
    logic       Tick;
    logic       LD;
    logic [2:0] IN_MT;
    logic [3:0] IN_MU;
    logic [2:0] IN_ST;
    logic [3:0] IN_SU;
    logic       Start;
    logic       Stop;
    logic [2:0] MT;
    logic [3:0] MU;
    logic [2:0] ST;
    logic [3:0] SU;
    logic       RUNNING;
    logic       DONE;
    logic       EXPIRED;
    logic [1:0] STATE;

    modport master (
        output Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop,
        input  MT, MU, ST, SU, RUNNING, DONE, EXPIRED, STATE
    );

    modport slave (
        input  Tick, LD, IN_MT, IN_MU, IN_ST, IN_SU, Start, Stop,
        output MT, MU, ST, SU, RUNNING, DONE, EXPIRED, STATE
    );
endinterface

// File: rtl/countdown_timer_mmss.sv
// BCD mm:ss down-counter with IDLE/RUN/PAUSE/RING control, a one-cycle DONE
// pulse on expiry and a Tick-counted ring period before returning to IDLE.
module countdown_timer_mmss #(
    parameter int unsigned RING_TICKS = 60
) (
    input  logic Clk,
    input  logic Clr,
    countdown_timer_mmss_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_RING  = 2'b11
    } state_t;

    state_t     state_q;
    logic [2:0] mt_q;
    logic [3:0] mu_q;
    logic [2:0] st_q;
    logic [3:0] su_q;
    logic       done_q;
    logic [7:0] ring_q;

    logic [2:0] mt_d;
    logic [3:0] mu_d;
    logic [2:0] st_d;
    logic [3:0] su_d;
    logic       borrow_su;
    logic       borrow_st;
    logic       borrow_mu;

    logic [2:0] ld_mt;
    logic [3:0] ld_mu;
    logic [2:0] ld_st;
    logic [3:0] ld_su;

    logic       count_zero;
    logic       count_one;

    // Load values saturate to the largest legal digit rather than wrapping.
    always_comb begin
        ld_mt = (bus.IN_MT > 3'd5) ? 3'd5 : bus.IN_MT;
        ld_mu = (bus.IN_MU > 4'd9) ? 4'd9 : bus.IN_MU;
        ld_st = (bus.IN_ST > 3'd5) ? 3'd5 : bus.IN_ST;
        ld_su = (bus.IN_SU > 4'd9) ? 4'd9 : bus.IN_SU;
    end

    // One-second borrow chain; each digit borrows only when every lower digit is 0.
    always_comb begin
        borrow_su = (su_q == 4'd0);
        su_d      = borrow_su ? 4'd9 : su_q - 4'd1;

        borrow_st = borrow_su && (st_q == 3'd0);
        st_d      = st_q;
        if (borrow_su) begin
            st_d = (st_q == 3'd0) ? 3'd5 : st_q - 3'd1;
        end

        borrow_mu = borrow_st && (mu_q == 4'd0);
        mu_d      = mu_q;
        if (borrow_st) begin
            mu_d = (mu_q == 4'd0) ? 4'd9 : mu_q - 4'd1;
        end

        mt_d = borrow_mu ? mt_q - 3'd1 : mt_q;
    end

    always_comb begin
        count_zero = (mt_q == 3'd0) && (mu_q == 4'd0) && (st_q == 3'd0) && (su_q == 4'd0);
        count_one  = (mt_q == 3'd0) && (mu_q == 4'd0) && (st_q == 3'd0) && (su_q == 4'd1);
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= S_IDLE;
            mt_q    <= '0;
            mu_q    <= '0;
            st_q    <= '0;
            su_q    <= '0;
            done_q  <= 1'b0;
            ring_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.LD) begin
                mt_q    <= ld_mt;
                mu_q    <= ld_mu;
                st_q    <= ld_st;
                su_q    <= ld_su;
                state_q <= S_IDLE;
                ring_q  <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!bus.Stop && bus.Start && !count_zero) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (bus.Stop) begin
                            state_q <= S_PAUSE;
                        end else if (bus.Tick && !count_zero) begin
                            mt_q <= mt_d;
                            mu_q <= mu_d;
                            st_q <= st_d;
                            su_q <= su_d;
                            if (count_one) begin
                                done_q  <= 1'b1;
                                state_q <= S_RING;
                                ring_q  <= 8'(RING_TICKS);
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!bus.Stop && bus.Start) begin
                            state_q <= S_RUN;
                        end
                    end
                    S_RING: begin
                        if (bus.Stop) begin
                            state_q <= S_IDLE;
                            ring_q  <= '0;
                        end else if (bus.Tick) begin
                            if (ring_q <= 8'd1) begin
                                state_q <= S_IDLE;
                                ring_q  <= '0;
                            end else begin
                                ring_q <= ring_q - 8'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.MT      = mt_q;
    assign bus.MU      = mu_q;
    assign bus.ST      = st_q;
    assign bus.SU      = su_q;
    assign bus.DONE    = done_q;
    assign bus.STATE   = state_q;
    assign bus.RUNNING = (state_q == S_RUN);
    assign bus.EXPIRED = (state_q == S_RING);

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Bench for countdown_timer_mmss: directed scenarios plus random traffic, each
// cycle compared against a seconds-based reference model.
module tb_countdown_timer_mmss;

    localparam int unsigned RT = 3;

    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    countdown_timer_mmss_if bus ();

    countdown_timer_mmss #(.RING_TICKS(RT)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the count is kept as total seconds.
    int m_secs;
    int m_state;   // 0 idle, 1 run, 2 pause, 3 ring
    int m_ring;
    bit m_done;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [13:0] pack(input int s);
        return {3'(s / 600), 4'((s / 60) % 10), 3'((s % 60) / 10), 4'(s % 10)};
    endfunction

    function automatic int clampv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic m_reset();
        m_secs = 0; m_state = 0; m_ring = 0; m_done = 0;
    endtask

    task automatic m_update();
        m_done = 0;
        if (bus.LD) begin
            m_secs = clampv(int'(bus.IN_MT), 5) * 600 + clampv(int'(bus.IN_MU), 9) * 60
                   + clampv(int'(bus.IN_ST), 5) * 10 + clampv(int'(bus.IN_SU), 9);
            m_state = 0;
            m_ring  = 0;
        end else begin
            case (m_state)
                0: if (!bus.Stop && bus.Start && m_secs != 0) m_state = 1;
                1: begin
                    if (bus.Stop) m_state = 2;
                    else if (bus.Tick && m_secs > 0) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_done  = 1;
                            m_state = 3;
                            m_ring  = RT;
                        end
                    end
                end
                2: if (!bus.Stop && bus.Start) m_state = 1;
                default: begin
                    if (bus.Stop) begin
                        m_state = 0; m_ring = 0;
                    end else if (bus.Tick) begin
                        m_ring = m_ring - 1;
                        if (m_ring <= 0) begin
                            m_state = 0; m_ring = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"},   {18'd0, bus.MT, bus.MU, bus.ST, bus.SU}, {18'd0, pack(m_secs)});
        check({tag, ".state"},   {30'd0, bus.STATE}, 32'(m_state));
        check({tag, ".running"}, {31'd0, bus.RUNNING}, {31'd0, m_state == 1});
        check({tag, ".done"},    {31'd0, bus.DONE}, {31'd0, m_done});
        check({tag, ".expired"}, {31'd0, bus.EXPIRED}, {31'd0, m_state == 3});
    endtask

    task automatic step(input string tag, input bit ld, input int a, input int b, input int c,
                        input int d, input bit start, input bit stop, input bit tick);
        bus.LD = ld;
        bus.IN_MT = 3'(a); bus.IN_MU = 4'(b); bus.IN_ST = 3'(c); bus.IN_SU = 4'(d);
        bus.Start = start; bus.Stop = stop; bus.Tick = tick;
        m_update();
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic load(input string tag, input int a, input int b, input int c, input int d);
        step(tag, 1'b1, a, b, c, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic go(input string tag, input bit start, input bit stop, input bit tick);
        step(tag, 1'b0, 0, 0, 0, 0, start, stop, tick);
    endtask

    initial begin
        Clr = 1'b1;
        bus.LD = 0; bus.Start = 0; bus.Stop = 0; bus.Tick = 0;
        bus.IN_MT = '0; bus.IN_MU = '0; bus.IN_ST = '0; bus.IN_SU = '0;
        m_reset();
        @(posedge Clk);
        #1;
        compare_all("reset");
        Clr = 1'b0;

        // 00:03 run to expiry, then let the ring period elapse
        load("ld3", 0, 0, 0, 3);
        go("start3", 1, 0, 0);
        go("t2", 0, 0, 1);
        go("t1", 0, 0, 1);
        go("t0", 0, 0, 1);
        check("done_at_zero", {31'd0, bus.DONE}, 32'd1);
        check("ring_state", {30'd0, bus.STATE}, 32'd3);
        go("after_done", 0, 0, 0);
        check("done_one_cycle", {31'd0, bus.DONE}, 32'd0);
        go("start_in_ring", 1, 0, 0);
        go("ring1", 0, 0, 1);
        go("ring2", 0, 0, 1);
        go("ring3", 0, 0, 1);
        check("ring_expired_drop", {31'd0, bus.EXPIRED}, 32'd0);

        // full borrow chains
        load("ld1000", 1, 0, 0, 0);
        go("start1000", 1, 0, 0);
        go("tick1000", 0, 0, 1);
        check("borrow_all", {18'd0, bus.MT, bus.MU, bus.ST, bus.SU}, {18'd0, 3'd0, 4'd9, 3'd5, 4'd9});
        load("ld0100", 0, 1, 0, 0);
        go("start0100", 1, 0, 0);
        go("tick0100", 0, 0, 1);
        check("borrow_min", {18'd0, bus.MT, bus.MU, bus.ST, bus.SU}, {18'd0, 3'd0, 4'd0, 3'd5, 4'd9});

        // pause / resume interplay with Tick
        load("ld45", 0, 0, 4, 5);
        go("start45", 1, 0, 0);
        go("stop_tick", 0, 1, 1);
        for (int i = 0; i < 5; i++) go("paused_tick", 0, 0, 1);
        go("pause_stop", 0, 1, 0);
        go("resume_tick", 1, 0, 1);
        go("tick44", 0, 0, 1);
        check("resume_dec", {18'd0, bus.MT, bus.MU, bus.ST, bus.SU}, {18'd0, 3'd0, 4'd0, 3'd4, 4'd4});
        go("start_stop_both", 1, 1, 1);

        // ring acknowledged by Stop
        load("ld01", 0, 0, 0, 1);
        go("start01", 1, 0, 0);
        go("expire", 0, 0, 1);
        go("ring_tick", 0, 0, 1);
        go("ring_ack", 0, 1, 0);

        // clamping and zero start
        load("clamp", 7, 12, 6, 15);
        check("clamp_val", {18'd0, bus.MT, bus.MU, bus.ST, bus.SU}, {18'd0, 3'd5, 4'd9, 3'd5, 4'd9});
        load("ld00", 0, 0, 0, 0);
        go("start_zero", 1, 0, 0);
        go("tick_idle", 0, 0, 1);

        // asynchronous clear with a Tick pending at 00:01
        load("ld01b", 0, 0, 0, 1);
        go("start01b", 1, 0, 0);
        bus.Tick = 1'b1;
        #2 Clr = 1'b1;
        #1;
        m_reset();
        compare_all("clr_async");
        Clr = 1'b0;
        go("after_clr", 0, 0, 1);

        // load while running
        load("ld320", 0, 3, 2, 0);
        go("start320", 1, 0, 0);
        go("tick320", 0, 0, 1);
        load("ld500_run", 0, 5, 0, 0);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            bit rld;
            int a, b, c, d;
            rld = ($urandom_range(0, 39) == 0);
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : 0;
            b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 0;
            c = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 15));
            step("rand", rld, a, b, c, d,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
